// File: rtl/jesd_dac_pattern_gen.sv
`default_nettype none
// ============================================================================
// jesd_dac_pattern_gen : multi-channel DAC test-pattern source (ID/ALT/RAMP/PRBS-15)
// Revision: 1.0
// ============================================================================
module jesd_dac_pattern_gen #(
   parameter int NUM_CHANNELS        = 4,
   parameter int SAMPLES_PER_CHANNEL = 2,
   parameter int SAMPLE_WIDTH        = 16,
   parameter int PHASE_LEN           = 256
) (
   input  logic                                                 device_clk,
   input  logic                                                 resetn,
   input  logic                                                 enable,
   input  logic                                                 restart,
   input  logic [1:0]                                           mode,
   input  logic                                                 dac_ready,
   output logic                                                 dac_valid,
   output logic [NUM_CHANNELS*SAMPLES_PER_CHANNEL*SAMPLE_WIDTH-1:0] dac_data,
   output logic [31:0]                                          sample_count,
   output logic                                                 phase
);

   localparam int c_data_w    = NUM_CHANNELS * SAMPLES_PER_CHANNEL * SAMPLE_WIDTH;
   localparam int c_phase_bit = $clog2(PHASE_LEN);

   localparam logic [1:0] c_mode_id   = 2'd0;
   localparam logic [1:0] c_mode_alt  = 2'd1;
   localparam logic [1:0] c_mode_ramp = 2'd2;
   localparam logic [1:0] c_mode_prbs = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_nxt;
   logic                w_hs;
   logic                w_load;
   logic                w_adv;
   logic                w_valid_nxt;
   logic [1:0]          r_mode;
   logic [1:0]          w_mode_sel;
   logic [31:0]         r_count;
   logic [31:0]         w_count_nxt;
   logic [c_data_w-1:0] w_beat;

   // PRBS-15, x^15 + x^14 + 1, shifting towards the MSB
   function automatic logic [14:0] lfsr_step(input logic [14:0] st);
      return {st[13:0], st[14] ^ st[13]};
   endfunction

   assign w_hs = dac_valid & dac_ready;

   always_ff @(posedge device_clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // w_load: beat 0 is (re)loaded; w_adv: the next beat replaces an accepted one
   always_comb begin
      w_state_nxt = r_state;
      w_load      = 1'b0;
      w_adv       = 1'b0;
      w_valid_nxt = dac_valid;
      case (r_state)
         S_IDLE: begin
            if (enable) begin
               w_state_nxt = S_RUN;
               w_load      = 1'b1;
               w_valid_nxt = 1'b1;
            end
         end
         S_RUN: begin
            if (restart) begin
               w_load      = 1'b1;
               w_valid_nxt = 1'b1;
            end else begin
               w_adv = w_hs;
               if (!enable) begin
                  if (!dac_valid || w_hs) begin
                     w_state_nxt = S_IDLE;
                     w_valid_nxt = 1'b0;
                  end else begin
                     w_state_nxt = S_DRAIN;
                  end
               end
            end
         end
         S_DRAIN: begin
            if (restart) begin
               w_load = 1'b1;
            end else if (w_hs) begin
               w_adv       = 1'b1;
               w_state_nxt = S_IDLE;
               w_valid_nxt = 1'b0;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
            w_valid_nxt = 1'b0;
         end
      endcase
   end

   assign w_mode_sel  = w_load ? mode : r_mode;
   assign w_count_nxt = w_load ? 32'd0 : r_count + 32'(SAMPLES_PER_CHANNEL);

   always_ff @(posedge device_clk or negedge resetn) begin
      if (!resetn) begin
         dac_valid <= 1'b0;
         dac_data  <= '0;
         r_count   <= '0;
         r_mode    <= c_mode_id;
      end else begin
         dac_valid <= w_valid_nxt;
         if (w_load || w_adv) begin
            dac_data <= w_beat;
            r_count  <= w_count_nxt;
            r_mode   <= w_mode_sel;
         end
      end
   end

   assign sample_count = r_count;
   assign phase        = r_count[c_phase_bit];

   for (genvar c = 0; c < NUM_CHANNELS; c++) begin : g_chan
      localparam logic [3:0]  c_id   = 4'(c);
      localparam logic [14:0] c_seed = 15'(c + 1);

      logic [14:0] r_lfsr;
      logic [14:0] w_adv_state;
      logic [14:0] w_start;
      logic [14:0] w_walk;
      logic [14:0] w_prbs [SAMPLES_PER_CHANNEL];

      // r_lfsr holds the state at the start of the current beat
      always_comb begin
         w_adv_state = r_lfsr;
         for (int k = 0; k < SAMPLES_PER_CHANNEL; k++) begin
            w_adv_state = lfsr_step(w_adv_state);
         end
         w_start = w_load ? c_seed : w_adv_state;
      end

      always_comb begin
         w_walk = w_start;
         for (int k = 0; k < SAMPLES_PER_CHANNEL; k++) begin
            w_walk    = lfsr_step(w_walk);
            w_prbs[k] = w_walk;
         end
      end

      always_ff @(posedge device_clk or negedge resetn) begin
         if (!resetn) begin
            r_lfsr <= c_seed;
         end else if (w_load || w_adv) begin
            r_lfsr <= w_start;
         end
      end

      for (genvar s = 0; s < SAMPLES_PER_CHANNEL; s++) begin : g_samp
         logic [SAMPLE_WIDTH-1:0] w_val;

         // PHASE_LEN is a multiple of the beat size, so one phase bit covers the beat
         always_comb begin
            w_val = {(SAMPLE_WIDTH/4){c_id}};
            case (w_mode_sel)
               c_mode_alt: begin
                  if (w_count_nxt[c_phase_bit]) begin
                     w_val                       = '0;
                     w_val[SAMPLE_WIDTH-1 -: 4]  = c_id;
                     w_val[7:0]                  = w_count_nxt[7:0] + 8'(s);
                  end
               end
               c_mode_ramp: begin
                  w_val = w_count_nxt[SAMPLE_WIDTH-1:0] + SAMPLE_WIDTH'(s)
                        + {c_id, {(SAMPLE_WIDTH-4){1'b0}}};
               end
               c_mode_prbs: begin
                  w_val = SAMPLE_WIDTH'(w_prbs[s]);
               end
               default: begin
               end
            endcase
         end

         assign w_beat[SAMPLE_WIDTH*(SAMPLES_PER_CHANNEL*c+s) +: SAMPLE_WIDTH] = w_val;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_jesd_dac_pattern_gen.sv
`default_nettype none
// ============================================================================
// tb_jesd_dac_pattern_gen : directed vector table plus corner-case sequences
// Revision: 1.0
// ============================================================================
module tb_jesd_dac_pattern_gen;

   logic         clk;
   logic         resetn;
   logic         enable;
   logic         restart;
   logic [1:0]   mode;
   logic         ready;
   logic         valid;
   logic [127:0] data;
   logic [31:0]  count;
   logic         phase;

   int checks = 0;
   int errors = 0;

   jesd_dac_pattern_gen #(
      .NUM_CHANNELS       (4),
      .SAMPLES_PER_CHANNEL(2),
      .SAMPLE_WIDTH       (16),
      .PHASE_LEN          (256)
   ) dut (
      .device_clk  (clk),
      .resetn      (resetn),
      .enable      (enable),
      .restart     (restart),
      .mode        (mode),
      .dac_ready   (ready),
      .dac_valid   (valid),
      .dac_data    (data),
      .sample_count(count),
      .phase       (phase)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        en;
      logic        rs;
      logic [1:0]  md;
      logic        rdy;
      logic        ev;
      logic [31:0] ecnt;
      logic [15:0] e1;
      logic [15:0] e3;
   } vec_t;

   vec_t tbl [18];

   function automatic vec_t mk(input logic en, input logic rs, input logic [1:0] md,
                               input logic rdy, input logic ev, input logic [31:0] ecnt,
                               input logic [15:0] e1, input logic [15:0] e3);
      vec_t v;
      v.en = en; v.rs = rs; v.md = md; v.rdy = rdy;
      v.ev = ev; v.ecnt = ecnt; v.e1 = e1; v.e3 = e3;
      return v;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_beat(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic wait_count(input logic [31:0] target);
      for (int k = 0; k < 400 && count !== target; k++) tick();
   endtask

   // ID / ALT / RAMP reference beat for M=4, S=2, W=16, PHASE_LEN=256
   function automatic logic [127:0] model_beat(input int md, input logic [31:0] cnt);
      logic [127:0] b;
      logic [15:0]  v;
      logic [31:0]  n;
      logic [3:0]   ci;
      b = '0;
      for (int c = 0; c < 4; c++) begin
         ci = 4'(c);
         for (int s = 0; s < 2; s++) begin
            n = cnt + 32'(s);
            case (md)
               1:       v = n[8] ? {ci, 4'h0, n[7:0]} : {4{ci}};
               2:       v = n[15:0] + {ci, 12'h000};
               default: v = {4{ci}};
            endcase
            b[16*(2*c+s) +: 16] = v;
         end
      end
      return b;
   endfunction

   initial begin
      bit   hs;
      int   beats;
      logic [31:0] exp_cnt;

      resetn  = 1'b0;
      enable  = 1'b0;
      restart = 1'b0;
      mode    = 2'd0;
      ready   = 1'b0;
      #2;
      check("reset_valid", {31'd0, valid}, 32'd0);
      check("reset_count", count, 32'd0);
      check("reset_phase", {31'd0, phase}, 32'd0);
      check_beat("reset_data", data, 128'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;

      tbl[0]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd0, 16'h1111, 16'h3333);
      tbl[1]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd2, 16'h1111, 16'h3333);
      tbl[2]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'd2, 16'h1111, 16'h3333);
      tbl[3]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'd2, 16'h1111, 16'h3333);
      tbl[4]  = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd4, 16'h1111, 16'h3333);
      tbl[5]  = mk(1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'd6, 16'h1111, 16'h3333);
      tbl[6]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 32'd6, 16'h1111, 16'h3333);
      tbl[7]  = mk(1'b1, 1'b0, 2'd0, 1'b0, 1'b1, 32'd6, 16'h1111, 16'h3333);
      tbl[8]  = mk(1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 32'd0, 16'h0000, 16'h0000);
      tbl[9]  = mk(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 32'd0, 16'h0000, 16'h0000);
      tbl[10] = mk(1'b1, 1'b0, 2'd2, 1'b0, 1'b1, 32'd0, 16'h1000, 16'h3001);
      tbl[11] = mk(1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'd2, 16'h1002, 16'h3003);
      tbl[12] = mk(1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 32'd4, 16'h1004, 16'h3005);
      tbl[13] = mk(1'b1, 1'b1, 2'd2, 1'b0, 1'b1, 32'd0, 16'h1000, 16'h3001);
      tbl[14] = mk(1'b1, 1'b1, 2'd0, 1'b1, 1'b1, 32'd0, 16'h1111, 16'h3333);
      tbl[15] = mk(1'b1, 1'b0, 2'd0, 1'b1, 1'b1, 32'd2, 16'h1111, 16'h3333);
      tbl[16] = mk(1'b1, 1'b1, 2'd3, 1'b0, 1'b1, 32'd0, 16'h0004, 16'h0010);
      tbl[17] = mk(1'b1, 1'b0, 2'd3, 1'b1, 1'b1, 32'd2, 16'h0010, 16'h0040);

      for (int i = 0; i < 18; i++) begin
         enable  = tbl[i].en;
         restart = tbl[i].rs;
         mode    = tbl[i].md;
         ready   = tbl[i].rdy;
         tick();
         check($sformatf("row%0d_valid", i), {31'd0, valid}, {31'd0, tbl[i].ev});
         if (tbl[i].ev) begin
            check($sformatf("row%0d_count", i), count, tbl[i].ecnt);
            check($sformatf("row%0d_ch1s0", i), {16'd0, data[32 +: 16]}, {16'd0, tbl[i].e1});
            check($sformatf("row%0d_ch3s1", i), {16'd0, data[112 +: 16]}, {16'd0, tbl[i].e3});
            check($sformatf("row%0d_ch0s0", i), {16'd0, data[0 +: 16]},
                  (tbl[i].md == 2'd3 && i == 16) ? 32'h0002 :
                  (tbl[i].md == 2'd3) ? 32'h0008 :
                  (tbl[i].e1 == 16'h1111) ? 32'h0000 : {16'd0, tbl[i].ecnt[15:0]});
         end
      end
      restart = 1'b0;

      // stop with the last beat accepted -> straight to IDLE
      enable = 1'b0;
      ready  = 1'b1;
      tick();
      check("stop_valid", {31'd0, valid}, 32'd0);
      restart = 1'b1;
      tick();
      check("idle_restart_valid", {31'd0, valid}, 32'd0);
      restart = 1'b0;

      // ALT phase boundary
      enable = 1'b1;
      mode   = 2'd1;
      ready  = 1'b1;
      tick();
      check("alt_start_count", count, 32'd0);
      mode = 2'd0;
      wait_count(32'd254);
      check("alt_cnt254", count, 32'd254);
      check("alt254_ch3s0", {16'd0, data[96 +: 16]}, 32'h3333);
      check("alt254_ch3s1", {16'd0, data[112 +: 16]}, 32'h3333);
      check("alt254_phase", {31'd0, phase}, 32'd0);
      tick();
      check("alt_cnt256", count, 32'd256);
      check("alt256_ch3s0", {16'd0, data[96 +: 16]}, 32'h3000);
      check("alt256_ch3s1", {16'd0, data[112 +: 16]}, 32'h3001);
      check("alt256_phase", {31'd0, phase}, 32'd1);
      wait_count(32'd510);
      check("alt510_ch3s1", {16'd0, data[112 +: 16]}, 32'h30FF);
      tick();
      check("alt_cnt512", count, 32'd512);
      check("alt512_ch3s0", {16'd0, data[96 +: 16]}, 32'h3333);
      check("alt512_phase", {31'd0, phase}, 32'd0);

      enable = 1'b0;
      tick();
      check("alt_stop_valid", {31'd0, valid}, 32'd0);

      // backpressure scoreboard in RAMP mode
      enable = 1'b1;
      mode   = 2'd2;
      ready  = 1'b0;
      tick();
      exp_cnt = 32'd0;
      beats   = 0;
      check_beat("sb_first", data, model_beat(2, exp_cnt));
      for (int cyc = 0; cyc < 10000 && beats < 1000; cyc++) begin
         ready = 1'($urandom_range(0, 1));
         hs    = (valid === 1'b1) && ready;
         tick();
         if (hs) begin
            exp_cnt = exp_cnt + 32'd2;
            beats++;
         end
         check("sb_valid", {31'd0, valid}, 32'd1);
         check("sb_count", count, exp_cnt);
         check_beat("sb_data", data, model_beat(2, exp_cnt));
      end
      check("sb_beats", beats, 32'd1000);

      // restart mid-stall in RAMP at count 100, then into PRBS
      restart = 1'b1;
      ready   = 1'b1;
      tick();
      restart = 1'b0;
      check("rs_zero", count, 32'd0);
      wait_count(32'd100);
      check("rs_cnt100", count, 32'd100);
      ready = 1'b0;
      tick();
      check("rs_stall_hold", count, 32'd100);
      restart = 1'b1;
      tick();
      check("rs_count", count, 32'd0);
      check("rs_valid", {31'd0, valid}, 32'd1);
      check("rs_ch1s0", {16'd0, data[32 +: 16]}, 32'h1000);
      mode = 2'd3;
      tick();
      restart = 1'b0;
      check("prbs_ch0s0", {16'd0, data[0 +: 16]}, 32'h0002);
      check("prbs_ch0s1", {16'd0, data[16 +: 16]}, 32'h0004);
      check("prbs_ch1s0", {16'd0, data[32 +: 16]}, 32'h0004);

      // stop with pending beat -> DRAIN -> IDLE
      mode   = 2'd0;
      enable = 1'b0;
      ready  = 1'b0;
      tick();
      check("drain_valid", {31'd0, valid}, 32'd1);
      check("drain_count", count, 32'd0);
      tick();
      check("drain_hold", {31'd0, valid}, 32'd1);
      ready = 1'b1;
      tick();
      check("drain_done", {31'd0, valid}, 32'd0);

      // asynchronous reset mid-stream
      enable = 1'b1;
      ready  = 1'b1;
      tick();
      tick();
      tick();
      #2;
      resetn = 1'b0;
      #1;
      check("areset_valid", {31'd0, valid}, 32'd0);
      check("areset_count", count, 32'd0);
      check_beat("areset_data", data, 128'd0);
      enable = 1'b0;
      @(posedge clk);
      @(negedge clk);
      resetn = 1'b1;
      tick();
      check("post_reset_valid", {31'd0, valid}, 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
